// File: rtl/led_pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module   : led_pulse_stretcher
// Purpose  : Turns single-cycle events into fixed on-time/off-gap LED flashes,
//            queueing events that arrive mid-flash. LED_PULSE_OVERFLOW_EN
//            enables the sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module led_pulse_stretcher #(
    parameter int ON_CLOCKS   = 5000000,
    parameter int GAP_CLOCKS  = 2500000,
    parameter int PENDING_MAX = 15
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               event_in,
    output logic                               led,
    output logic                               busy,
    output logic [$clog2(PENDING_MAX+1)-1:0]   pending,
    output logic                               overflow
);

    localparam int c_CNT_MAX  = (ON_CLOCKS > GAP_CLOCKS) ? ON_CLOCKS : GAP_CLOCKS;
    localparam int c_CNT_W    = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam int c_PEND_W   = $clog2(PENDING_MAX + 1);

    localparam logic [c_CNT_W-1:0]  c_ON_LOAD  = c_CNT_W'(ON_CLOCKS - 1);
    localparam logic [c_CNT_W-1:0]  c_GAP_LOAD = c_CNT_W'(GAP_CLOCKS - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PEND_W-1:0] c_PEND_MAX = c_PEND_W'(PENDING_MAX);
    localparam logic [c_PEND_W-1:0] c_PEND_ONE = c_PEND_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ON   = 2'd1;
    localparam logic [1:0] c_GAP  = 2'd2;

    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_PEND_W-1:0] r_pending;
    logic                r_led;
    logic                r_busy;

    logic [1:0]          w_state_nxt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [c_PEND_W-1:0] w_pending_nxt;
    logic                w_cnt_zero;
    logic                w_pend_full;

    assign w_cnt_zero  = (r_cnt == '0);
    assign w_pend_full = (r_pending == c_PEND_MAX);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pending_nxt = r_pending;
        case (r_state)
            c_IDLE: begin
                if (event_in) begin
                    w_state_nxt = c_ON;
                    w_cnt_nxt   = c_ON_LOAD;
                end
            end
            c_ON: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end else begin
                    w_state_nxt = c_GAP;
                    w_cnt_nxt   = c_GAP_LOAD;
                end
                if (event_in && !w_pend_full) begin
                    w_pending_nxt = r_pending + c_PEND_ONE;
                end
            end
            c_GAP: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                    if (event_in && !w_pend_full) begin
                        w_pending_nxt = r_pending + c_PEND_ONE;
                    end
                end else if (r_pending != '0) begin
                    // Dequeue; a coincident event replaces the one taken out.
                    w_state_nxt = c_ON;
                    w_cnt_nxt   = c_ON_LOAD;
                    if (!event_in) begin
                        w_pending_nxt = r_pending - c_PEND_ONE;
                    end
                end else if (event_in) begin
                    w_state_nxt = c_ON;
                    w_cnt_nxt   = c_ON_LOAD;
                end else begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_pending <= '0;
            r_led     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pending_nxt;
            r_led     <= (w_state_nxt == c_ON);
            r_busy    <= (w_state_nxt != c_IDLE);
        end
    end

    assign led     = r_led;
    assign busy    = r_busy;
    assign pending = r_pending;

`ifdef LED_PULSE_OVERFLOW_EN
    logic w_drop;
    logic r_overflow;

    // The final GAP cycle always dequeues, so it can never drop an event.
    assign w_drop = event_in && w_pend_full &&
                    ((r_state == c_ON) || ((r_state == c_GAP) && !w_cnt_zero));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`else
    assign overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/led_pulse_stretcher.md
# led_pulse_stretcher

Output-side counterpart to the button debouncer. It takes the single-cycle event pulses the board logic produces, such as debounced presses, auto-repeat ticks and game events, and turns each one into a human-visible LED flash. Each flash is a fixed-length on-time followed by a mandatory off-gap, so every event in a burst shows as its own blink. Events arriving while a flash is in progress are queued in a saturating pending counter. The block sits between the control FSMs and the board LED pins.

## Interface
Parameters:
- `ON_CLOCKS`, 5000000: LED on-time per event, in clk cycles (100 ms at 50 MHz). Must be ≥1.
- `GAP_CLOCKS`, 2500000: forced LED off-time after each flash, in cycles (50 ms). Must be ≥1.
- `PENDING_MAX`, 15: saturation value of the queued-event counter. Must be ≥1.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `event_in`  in  1  single-cycle event pulse. A level held high counts as one event per cycle.
- `led`  out  1  registered LED drive, active high.
- `busy`  out  1  high whenever the state is not IDLE.
- `pending`  out  $clog2(PENDING_MAX+1)  number of queued events not yet shown.
- `overflow`  out  1  sticky flag: an event was dropped because the queue was saturated.

## Operation
- States: IDLE, ON, GAP. One down-counter `cnt`, width $clog2(max(ON_CLOCKS,GAP_CLOCKS)).
- **IDLE:** `event_in`=1 moves to ON with `cnt`=ON_CLOCKS-1. `pending` stays 0.
- **ON:** `led`=1.
  - `cnt`≠0: decrement.
  - `cnt`=0: move to GAP with `cnt`=GAP_CLOCKS-1.
- **GAP:** `led`=0.
  - `cnt`≠0: decrement.
  - `cnt`=0 and `pending`>0: move to ON with `cnt`=ON_CLOCKS-1, and `pending` decrements.
  - `cnt`=0 and `pending`=0: move to IDLE.
- **Queueing:** `event_in`=1 in ON or GAP increments `pending`, saturating at PENDING_MAX.
- **Simultaneous event and dequeue** on the final GAP cycle: `pending` is unchanged (+1−1). This holds even at PENDING_MAX, so no drop occurs and `overflow` is not set.
- **Final GAP cycle with `pending`=0 and `event_in`=1:** move directly to ON. `pending` stays 0. The block must not pass through IDLE.
- **Drop condition:** an event arriving in ON/GAP with `pending`=PENDING_MAX and no dequeue in the same cycle.
- **Reset:** `reset`=1 at any time, including mid-flash, forces IDLE. It clears `cnt`, `pending`, `overflow` and `led` on the next edge. Any `event_in` in the reset cycle is ignored.

## Timing
- Reset values: `led`=0, `busy`=0, `pending`=0, `overflow`=0.
- All outputs are registered. `led`, `busy`, `pending` and `overflow` change on the edge after the causing input.
- Latency: `event_in` sampled at edge N gives `led`=1 from edge N+1.
- Each flash is exactly ON_CLOCKS cycles high, followed by exactly GAP_CLOCKS cycles low. Queued flashes are therefore spaced ON_CLOCKS+GAP_CLOCKS apart.
- `busy` covers every ON and GAP cycle and drops on the edge that enters IDLE.
- `pending` updates on the same edge as the state change it accompanies.

## Configuration
- `LED_PULSE_OVERFLOW_EN` defined: `overflow` is implemented. It is set on the edge following a drop condition and held until `reset`.
- `LED_PULSE_OVERFLOW_EN` not defined: `overflow` is tied to 0, and no flag register is synthesized.
- Counter saturation is identical in both builds.

## Test plan
All scenarios use ON_CLOCKS=4, GAP_CLOCKS=2, PENDING_MAX=3 and the macro defined.
- **Single pulse:** one-cycle `event_in` at edge 10 → `led` high on edges 11–14, low from edge 15. `busy` is high on edges 11–16 and 0 from edge 17.
- **Burst of 3:** pulses at edges 10, 11, 12 → `pending` reads 1, then 2. Three 4-high/2-low flashes follow back-to-back, and `pending` returns to 0 with the third flash.
- **Saturation:** 6 consecutive event cycles from IDLE → `pending` reaches 3 and `overflow` goes 1 and stays 1. Exactly 4 flashes are produced in total.
- **Boundary cases:**
  - Event on the final GAP cycle with `pending`=0 → ON on the next edge, with `led` low for exactly 2 cycles.
  - Event on the final GAP cycle with `pending`=3 → `pending` stays 3 and `overflow` stays 0.
- **Mid-flash reset:** `reset` asserted on the 2nd ON cycle with `pending`=2 → next edge gives `led`=0, `pending`=0, `busy`=0, `overflow`=0. An event on the following cycle flashes normally.
- **Macro undefined:** rerun the saturation scenario → `overflow` is constantly 0, and the flash count is unchanged at 4.
